// File: rtl/dispatch_bundle_queue_pkg.sv
// Shared types for the dispatch bundle queue: the per-entry record, the lane-count width,
// and the lane popcount helper.
package dispatch_bundle_queue_pkg;

  localparam int DISPATCH_WIDTH = 4;
  localparam int DIS_PKT_SIZE   = 16;
  localparam int LCNT_W         = $clog2(DISPATCH_WIDTH + 1);

  typedef logic [LCNT_W-1:0] lcnt_t;

  typedef struct packed {
    logic [DISPATCH_WIDTH*DIS_PKT_SIZE-1:0] pkt;
    logic [DISPATCH_WIDTH-1:0]              laneValid;
    lcnt_t                                  iqCnt;
    lcnt_t                                  alCnt;
    lcnt_t                                  ldCnt;
    lcnt_t                                  stCnt;
  } dbq_entry_t;

  function automatic lcnt_t popcount(input logic [DISPATCH_WIDTH-1:0] v);
    lcnt_t c;
    c = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) c = c + lcnt_t'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/dispatch_bundle_queue_if.sv
// Rename-side bundle handshake plus dispatch-side head bundle.
// Handshake: a bundle transfers on a clock edge where bundleValid_i=1 and stall_o=0 (flush
// suppresses it); the head transfers downstream in any cycle where dispatch_o=1.
interface dispatch_bundle_queue_if;
  import dispatch_bundle_queue_pkg::*;

  logic                                   bundleValid_i;
  logic [DISPATCH_WIDTH*DIS_PKT_SIZE-1:0] pkt_i;
  logic [DISPATCH_WIDTH-1:0]              laneValid_i;
  logic [DISPATCH_WIDTH-1:0]              needIQ_i;
  logic [DISPATCH_WIDTH-1:0]              isLoad_i;
  logic [DISPATCH_WIDTH-1:0]              isStore_i;
  logic                                   stall_o;

  logic                                   dispatch_o;
  logic [DISPATCH_WIDTH*DIS_PKT_SIZE-1:0] pkt_o;
  logic [DISPATCH_WIDTH-1:0]              laneValid_o;
  lcnt_t                                  iqCnt_o;
  lcnt_t                                  alCnt_o;
  lcnt_t                                  ldCnt_o;
  lcnt_t                                  stCnt_o;

  modport master (
    output bundleValid_i, pkt_i, laneValid_i, needIQ_i, isLoad_i, isStore_i,
    input  stall_o, dispatch_o, pkt_o, laneValid_o, iqCnt_o, alCnt_o, ldCnt_o, stCnt_o
  );

  modport slave (
    input  bundleValid_i, pkt_i, laneValid_i, needIQ_i, isLoad_i, isStore_i,
    output stall_o, dispatch_o, pkt_o, laneValid_o, iqCnt_o, alCnt_o, ldCnt_o, stCnt_o
  );
endinterface

// File: rtl/dispatch_bundle_queue_popcount.sv
// Lane popcount used on the enqueue path to precompute per-bundle resource needs.
module dbq_popcount
  import dispatch_bundle_queue_pkg::*;
(
  input  logic [DISPATCH_WIDTH-1:0] i_vec,
  output lcnt_t                     o_cnt
);
  assign o_cnt = popcount(i_vec);
endmodule

// File: rtl/dispatch_bundle_queue.sv
// In-order bundle FIFO between rename and dispatch; releases the head bundle only when every
// downstream structure can absorb the whole bundle. Lane width/packet size come from the package.
module dispatch_bundle_queue
  import dispatch_bundle_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic [CNT_W-1:0]       iqFree_i,
  input  logic [CNT_W-1:0]       alFree_i,
  input  logic [CNT_W-1:0]       ldqFree_i,
  input  logic [CNT_W-1:0]       stqFree_i,
  dispatch_bundle_queue_if.slave bus,
  output logic [31:0]            resStallCnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [31:0]      r_res_stall;
  dbq_entry_t       r_mem [DEPTH];

  logic [DISPATCH_WIDTH-1:0] w_lv;
  lcnt_t      w_iq, w_al, w_ld, w_st;
  dbq_entry_t w_new;
  dbq_entry_t w_head;
  logic       w_full, w_enq, w_room, w_deq;

  assign w_lv = bus.laneValid_i;

  dbq_popcount u_pc_iq (.i_vec(bus.needIQ_i & w_lv),  .o_cnt(w_iq));
  dbq_popcount u_pc_al (.i_vec(w_lv),                 .o_cnt(w_al));
  dbq_popcount u_pc_ld (.i_vec(bus.isLoad_i & w_lv),  .o_cnt(w_ld));
  dbq_popcount u_pc_st (.i_vec(bus.isStore_i & w_lv), .o_cnt(w_st));

  assign w_new = '{pkt: bus.pkt_i, laneValid: w_lv,
                   iqCnt: w_iq, alCnt: w_al, ldCnt: w_ld, stCnt: w_st};

  // Full is taken from the registered count so stall never depends on downstream free counts.
  assign w_full = (r_count == FULL_CNT);
  assign w_enq  = bus.bundleValid_i & ~w_full & ~flush_i;
  assign w_head = r_mem[r_head];
  assign w_room = (iqFree_i  >= CNT_W'(w_head.iqCnt)) &
                  (alFree_i  >= CNT_W'(w_head.alCnt)) &
                  (ldqFree_i >= CNT_W'(w_head.ldCnt)) &
                  (stqFree_i >= CNT_W'(w_head.stCnt));
  assign w_deq  = (r_count != '0) & ~flush_i & w_room;

  assign bus.stall_o     = w_full;
  assign bus.dispatch_o  = w_deq;
  assign bus.pkt_o       = w_head.pkt;
  assign bus.laneValid_o = w_deq ? w_head.laneValid : '0;
  assign bus.iqCnt_o     = w_deq ? w_head.iqCnt : '0;
  assign bus.alCnt_o     = w_deq ? w_head.alCnt : '0;
  assign bus.ldCnt_o     = w_deq ? w_head.ldCnt : '0;
  assign bus.stCnt_o     = w_deq ? w_head.stCnt : '0;
  assign resStallCnt_o   = r_res_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_res_stall <= '0;
    end else begin
      if ((r_count != '0) && !w_deq && !flush_i) r_res_stall <= r_res_stall + 32'd1;
      if (flush_i) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        if (w_enq) r_tail <= r_tail + 1'b1;
        if (w_deq) r_head <= r_head + 1'b1;
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= w_new;
  end

endmodule

// File: tb/tb_dispatch_bundle_queue.sv
// Bench for dispatch_bundle_queue: table vectors plus hand-written multi-cycle sequences,
// checked against a queue model of the bundle FIFO.
module tb_dispatch_bundle_queue;
  import dispatch_bundle_queue_pkg::*;

  localparam int EW = $bits(dbq_entry_t);
  localparam int PW = DISPATCH_WIDTH * DIS_PKT_SIZE;

  typedef struct {
    logic [PW-1:0]             pkt;
    logic [DISPATCH_WIDTH-1:0] lv, niq, ld, st;
    int                        e_iq, e_al, e_ld, e_st;
  } vec_t;

  typedef struct {
    logic [PW-1:0]             pkt;
    logic [DISPATCH_WIDTH-1:0] lv, niq, ld, st;
  } in_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic [7:0]  iqFree_i, alFree_i, ldqFree_i, stqFree_i;
  logic [31:0] resStallCnt_o;

  dispatch_bundle_queue_if bus ();

  dispatch_bundle_queue dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush_i),
    .iqFree_i      (iqFree_i),
    .alFree_i      (alFree_i),
    .ldqFree_i     (ldqFree_i),
    .stqFree_i     (stqFree_i),
    .bus           (bus.slave),
    .resStallCnt_o (resStallCnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0] m_rs = '0;
  dbq_entry_t  cur_exp;
  in_t         pend[$];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_bundle(input in_t b);
    bus.bundleValid_i = 1'b1;
    bus.pkt_i         = b.pkt;
    bus.laneValid_i   = b.lv;
    bus.needIQ_i      = b.niq;
    bus.isLoad_i      = b.ld;
    bus.isStore_i     = b.st;
    cur_exp.pkt       = b.pkt;
    cur_exp.laneValid = b.lv;
    cur_exp.iqCnt     = lcnt_t'($countones(b.niq & b.lv));
    cur_exp.alCnt     = lcnt_t'($countones(b.lv));
    cur_exp.ldCnt     = lcnt_t'($countones(b.ld & b.lv));
    cur_exp.stCnt     = lcnt_t'($countones(b.st & b.lv));
  endtask

  task automatic set_free(input logic [7:0] iq, al, ld, st);
    iqFree_i = iq; alFree_i = al; ldqFree_i = ld; stqFree_i = st;
  endtask

  // One clock: compare at negedge against the model, then advance the model.
  task automatic step(output bit acc);
    dbq_entry_t h;
    bit m_full, enq, deq;
    @(negedge clk);
    m_full = (exp_q.size() == 4);
    enq    = bus.bundleValid_i && !m_full && !flush_i;
    deq    = 1'b0;
    if (exp_q.size() != 0 && !flush_i) begin
      h   = dbq_entry_t'(exp_q[0]);
      deq = (iqFree_i >= h.iqCnt) && (alFree_i >= h.alCnt) &&
            (ldqFree_i >= h.ldCnt) && (stqFree_i >= h.stCnt);
    end
    check("stall_o", bus.stall_o, m_full);
    check("dispatch_o", bus.dispatch_o, deq);
    check("resStallCnt_o", resStallCnt_o, m_rs);
    if (deq) begin
      check("pkt_o", bus.pkt_o, h.pkt);
      check("laneValid_o", bus.laneValid_o, h.laneValid);
      check("iqCnt_o", bus.iqCnt_o, h.iqCnt);
      check("alCnt_o", bus.alCnt_o, h.alCnt);
      check("ldCnt_o", bus.ldCnt_o, h.ldCnt);
      check("stCnt_o", bus.stCnt_o, h.stCnt);
    end else begin
      check("idle_counts", {bus.iqCnt_o, bus.alCnt_o, bus.ldCnt_o, bus.stCnt_o}, 0);
    end
    if (exp_q.size() != 0 && !deq && !flush_i) m_rs++;
    if (flush_i) exp_q.delete();
    else begin
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back(cur_exp);
    end
    acc = enq;
    @(posedge clk);
    #1;
  endtask

  // Upstream behaviour: hold the front pending bundle until it is accepted.
  task automatic run_pending(input int cycles);
    bit acc;
    for (int c = 0; c < cycles; c++) begin
      if (pend.size() != 0) set_bundle(pend[0]);
      else bus.bundleValid_i = 1'b0;
      step(acc);
      if (acc) void'(pend.pop_front());
    end
    bus.bundleValid_i = 1'b0;
  endtask

  function automatic in_t rand_bundle(input logic [DISPATCH_WIDTH-1:0] lv_min);
    in_t b;
    b.pkt = {$urandom(), $urandom()};
    b.lv  = 4'($urandom_range(0, 15)) | lv_min;
    b.niq = 4'($urandom_range(0, 15)) | lv_min;
    b.ld  = 4'($urandom_range(0, 15));
    b.st  = 4'($urandom_range(0, 15));
    return b;
  endfunction

  initial begin
    bit acc;
    in_t b;

    vecs[0] = '{64'h1111_2222_3333_4444, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4, 4, 0, 0};
    vecs[1] = '{64'hA5A5_0000_5A5A_0000, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 2, 2, 0, 0};
    vecs[2] = '{64'hDEAD_BEEF_0000_0001, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 0, 0, 0, 0};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 4'b1011, 4'b0011, 4'b1000, 4'b0010, 2, 3, 1, 1};
    vecs[4] = '{64'hFEDC_BA98_7654_3210, 4'b1110, 4'b0110, 4'b0110, 4'b1000, 2, 3, 2, 1};
    vecs[5] = '{64'h0000_0000_0000_00FF, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 1, 1, 0};

    reset_n = 1'b0;
    flush_i = 1'b0;
    bus.bundleValid_i = 1'b0;
    bus.pkt_i = '0; bus.laneValid_i = '0; bus.needIQ_i = '0;
    bus.isLoad_i = '0; bus.isStore_i = '0;
    set_free(8, 8, 8, 8);
    cur_exp = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_stall", bus.stall_o, 0);
    check("reset_dispatch", bus.dispatch_o, 0);
    check("reset_counts", {bus.iqCnt_o, bus.alCnt_o, bus.ldCnt_o, bus.stCnt_o}, 0);
    check("reset_resstall", resStallCnt_o, 0);
    reset_n = 1'b1;

    // table vectors: accept on one edge, dispatch on the next
    for (int i = 0; i < 6; i++) begin
      b = '{vecs[i].pkt, vecs[i].lv, vecs[i].niq, vecs[i].ld, vecs[i].st};
      set_bundle(b);
      cur_exp.iqCnt = lcnt_t'(vecs[i].e_iq);
      cur_exp.alCnt = lcnt_t'(vecs[i].e_al);
      cur_exp.ldCnt = lcnt_t'(vecs[i].e_ld);
      cur_exp.stCnt = lcnt_t'(vecs[i].e_st);
      step(acc);
      check("vec_accept", acc, 1);
      bus.bundleValid_i = 1'b0;
      step(acc);
    end

    // six back-to-back bundles with ample resources
    for (int i = 0; i < 6; i++) pend.push_back(rand_bundle(4'b0000));
    run_pending(9);
    check("b2b_drained", exp_q.size() + pend.size(), 0);

    // IQ blocked: fill the queue, hold a fifth, then release
    set_free(0, 8, 8, 8);
    for (int i = 0; i < 5; i++) pend.push_back(rand_bundle(4'b0001));
    run_pending(8);
    check("held_pending", pend.size(), 1);
    set_free(8, 8, 8, 8);
    run_pending(10);
    check("held_drained", exp_q.size() + pend.size(), 0);

    // LDQ short by one entry
    set_free(8, 8, 1, 8);
    b = '{64'h0BAD_F00D_CAFE_0002, 4'b1111, 4'b0000, 4'b0011, 4'b0000};
    set_bundle(b);
    step(acc);
    bus.bundleValid_i = 1'b0;
    for (int i = 0; i < 3; i++) step(acc);
    ldqFree_i = 8'd2;
    #1;
    check("ldq_release_dispatch", bus.dispatch_o, 1);
    check("ldq_release_ldcnt", bus.ldCnt_o, 2);
    step(acc);

    // flush with three queued and a bundle offered
    set_free(0, 8, 8, 8);
    for (int i = 0; i < 3; i++) pend.push_back(rand_bundle(4'b0001));
    run_pending(3);
    set_bundle(rand_bundle(4'b0001));
    flush_i = 1'b1;
    step(acc);
    check("flush_no_accept", acc, 0);
    flush_i = 1'b0;
    bus.bundleValid_i = 1'b0;
    set_free(8, 8, 8, 8);
    for (int i = 0; i < 3; i++) step(acc);

    // asynchronous reset mid-run with three queued
    set_free(0, 8, 8, 8);
    for (int i = 0; i < 3; i++) pend.push_back(rand_bundle(4'b0001));
    run_pending(3);
    reset_n = 1'b0;
    #1;
    check("midreset_stall", bus.stall_o, 0);
    check("midreset_dispatch", bus.dispatch_o, 0);
    check("midreset_counts", {bus.iqCnt_o, bus.alCnt_o, bus.ldCnt_o, bus.stCnt_o}, 0);
    check("midreset_resstall", resStallCnt_o, 0);
    exp_q.delete();
    m_rs = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_free(8, 8, 8, 8);
    for (int i = 0; i < 2; i++) step(acc);

    // random traffic with varying resources
    for (int i = 0; i < 20; i++) pend.push_back(rand_bundle(4'b0000));
    for (int c = 0; c < 60; c++) begin
      set_free(8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
               8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)));
      run_pending(1);
    end
    set_free(8, 8, 8, 8);
    run_pending(30);
    check("final_drained", exp_q.size() + pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
